// File: rtl/serializador_8b_if.sv
`default_nettype none
// ============================================================================
// Module      : serializador_8b_if
// Description : Byte-side handshake and serial output bundle of the
//               byte-to-bit serializer. The valid_count member exists only
//               when SERIALIZADOR_CONTADOR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serializador_8b_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic       byte_req;
   logic       data_out;
   logic       active;
`ifdef SERIALIZADOR_CONTADOR_EN
   logic [15:0] valid_count;

   // Upstream byte source / downstream sink of the serial line
   modport master (output data_in, valid_in,
                   input  byte_req, data_out, active, valid_count);
   // Serializer side
   modport slave  (input  data_in, valid_in,
                   output byte_req, data_out, active, valid_count);
`else
   // Upstream byte source / downstream sink of the serial line
   modport master (output data_in, valid_in,
                   input  byte_req, data_out, active);
   // Serializer side
   modport slave  (input  data_in, valid_in,
                   output byte_req, data_out, active);
`endif
endinterface
`default_nettype wire

// File: rtl/serializador_8b.sv
`default_nettype none
// ============================================================================
// Module      : serializador_8b
// Description : Parallel-to-serial stage, one byte every 8 clk_8f cycles,
//               shifted out MSB first. A run of SYNC_BYTES commas follows
//               every reset; empty byte slots are filled with COMMA.
//               Optional macro SERIALIZADOR_CONTADOR_EN adds a saturating
//               count of accepted valid bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module serializador_8b #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned SYNC_BYTES = 4        // legal range 1..15
) (
   input wire logic          clk_8f,
   input wire logic          reset,
   serializador_8b_if.slave  bus
);

   typedef enum logic [0:0] {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic [6:0] shreg_q,    shreg_d;
   logic [3:0] sync_cnt_q, sync_cnt_d;
   state_t     state_q,    state_d;
   logic       byte_req_q, byte_req_d;
   logic       data_out_q, data_out_d;
   logic       active_q,   active_d;
   logic       capture;
   logic [7:0] sel_byte;

   // Byte-phase counter, byte selection, shifter and sync run sequencing
   always_comb begin
      capture    = (bit_cnt_q == 3'd0);
      bit_cnt_d  = bit_cnt_q + 3'd1;
      // Raised one cycle ahead so upstream presents the byte in time for capture
      byte_req_d = (bit_cnt_q == 3'd7);

      // Sync bytes and empty slots both carry the comma
      sel_byte = COMMA;
      if ((state_q == ST_ACTIVE) && bus.valid_in) begin
         sel_byte = bus.data_in;
      end

      shreg_d    = {shreg_q[5:0], 1'b0};
      data_out_d = shreg_q[6];
      sync_cnt_d = sync_cnt_q;
      state_d    = state_q;
      active_d   = active_q;

      if (capture) begin
         data_out_d = sel_byte[7];
         shreg_d    = sel_byte[6:0];
         if (state_q == ST_SYNC) begin
            sync_cnt_d = sync_cnt_q + 4'd1;
            // Last comma of the run loaded: the next slot honours valid_in
            if (sync_cnt_q == SYNC_LAST) begin
               state_d  = ST_ACTIVE;
               active_d = 1'b1;
            end
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_8f) begin
      if (reset) begin
         bit_cnt_q  <= 3'd7;
         shreg_q    <= 7'd0;
         sync_cnt_q <= 4'd0;
         state_q    <= ST_SYNC;
         byte_req_q <= 1'b0;
         data_out_q <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         sync_cnt_q <= sync_cnt_d;
         state_q    <= state_d;
         byte_req_q <= byte_req_d;
         data_out_q <= data_out_d;
         active_q   <= active_d;
      end
   end

   assign bus.byte_req = byte_req_q;
   assign bus.data_out = data_out_q;
   assign bus.active   = active_q;

`ifdef SERIALIZADOR_CONTADOR_EN
   logic [15:0] valid_count_q, valid_count_d;

   // Saturating count of data bytes actually accepted
   always_comb begin
      valid_count_d = valid_count_q;
      if (capture && (state_q == ST_ACTIVE) && bus.valid_in &&
          (valid_count_q != 16'hFFFF)) begin
         valid_count_d = valid_count_q + 16'd1;
      end
   end

   // Counter register, cleared only by reset
   always_ff @(posedge clk_8f) begin
      if (reset) begin
         valid_count_q <= 16'd0;
      end else begin
         valid_count_q <= valid_count_d;
      end
   end

   assign bus.valid_count = valid_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/serializador_8b.md
# serializador_8b

Byte-to-bit parallel-to-serial stage of the transmit path, downstream of the clock generator in the same `clk_8f` domain. It accepts one 8-bit byte every 8 `clk_8f` cycles, which is the `clk_f` byte rate, and shifts it out MSB first on a single serial line. Each link start is preceded by a fixed run of comma bytes. Any byte slot without valid data is filled with the comma. Its own byte-phase counter drives `byte_req`, so upstream logic aligns to the serializer and needs no second clock.

## Interface
- `COMMA`, 8'hBC: byte transmitted during sync and for every empty slot.
- `SYNC_BYTES`, 4: number of commas sent after reset before data is accepted; range 1..15.
- `clk_8f` in 1: single clock, 8x byte rate; all logic on rising edge.
- `reset` in 1: synchronous, active-high; sampled on `clk_8f` rising edge.
- `data_in` in 8: parallel byte, sampled only on capture edges.
- `valid_in` in 1: qualifies `data_in` on capture edges.
- `byte_req` out 1: registered; high for exactly the one cycle whose closing edge is a capture edge.
- `data_out` out 1: registered serial bit, MSB first.
- `active` out 1: registered; 1 once the sync run has been loaded.
- `valid_count` out 16: present only with `SERIALIZADOR_CONTADOR_EN`; saturating count of valid bytes accepted.

## Operation
- Registers:
  - `bit_cnt[2:0]`
  - shift register `shreg[6:0]`
  - `sync_cnt[3:0]`
  - state `SYNC`/`ACTIVE`
- Reset values:
  - `bit_cnt`=7, `shreg`=0, `sync_cnt`=0, state=`SYNC`
  - `byte_req`=0, `data_out`=0, `active`=0, `valid_count`=0
- `bit_cnt` increments on every edge while `reset` is low and wraps 7->0. `byte_req` is assigned the next-state condition `bit_cnt`==7.
- A capture edge is any edge with `reset` low and `bit_cnt`==0. On it the selected byte B is:
  - state `SYNC`: `COMMA`, with `valid_in` and `data_in` ignored; the byte is dropped, not buffered.
  - state `ACTIVE`, `valid_in`=1: `data_in`.
  - state `ACTIVE`, `valid_in`=0: `COMMA`.
- On a capture edge: `data_out`<=B[7] and `shreg`<=B[6:0].
- On any other edge: `data_out`<=`shreg`[6] and `shreg`<={`shreg`[5:0],0}.
- SYNC handling on a capture edge:
  - `sync_cnt` increments.
  - On the capture edge where `sync_cnt`==`SYNC_BYTES`-1, state<=`ACTIVE` and `active`<=1 on that same edge.
  - The first capture that honours `valid_in` is therefore the following one.
- `ACTIVE` is left only by `reset`.
- Reset mid-byte: on the reset edge all registers take their reset values, the partial byte is discarded, and `data_out` reads 0 in the next cycle. The sync run restarts from zero after `reset` is released.

## Timing
- Reset is released at edge E0, the first edge with `reset` low.
  - After E0: `bit_cnt`=0 and `byte_req`=1.
  - E1 is the first capture edge.
  - Capture edges then occur every 8 edges: E1, E9, E17, ...
- Latency: a byte captured at edge Ek drives bit7 on `data_out` in the cycle after Ek and bit0 in the cycle after Ek+7. The next byte's bit7 follows immediately, so there is no gap between bytes.
- Handshake: upstream must hold `data_in`/`valid_in` stable across the `byte_req`=1 cycle. Values outside that cycle have no effect.
- After reset release, `active` rises at edge E(1+8·(`SYNC_BYTES`-1)): E25 for default 4.
- Serial stream: exactly one bit per cycle and continuous; no idle value other than comma bits exists after E1.

## Configuration
- `SERIALIZADOR_CONTADOR_EN` defined:
  - Adds port `valid_count[15:0]`.
  - Increments on each capture edge in state `ACTIVE` with `valid_in`=1.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared only by `reset`.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

## Test plan
- Reset held 3 cycles, then released -> `byte_req` high only in cycles after E0, E8, E16, ...; `data_out` carries 10111100 four times in E1..E32; `active`=1 after E25.
- After sync, `data_in`=8'hA5 with `valid_in`=1 at E33 -> `data_out`=1,0,1,0,0,1,0,1 in the cycles after E33..E40.
- `valid_in`=0 at E41 with `data_in`=8'hFF -> comma 10111100 transmitted; `valid_count` unchanged.
- `valid_in`=1 with `data_in`=8'h00 held during the sync window -> only commas sent; `valid_count`=0 at E25.
- `reset` asserted for one edge at the 4th bit of a data byte -> `data_out`=0, `active`=0, `byte_req`=0 next cycle; sync run of 4 commas restarts from the next E1.
- With `SERIALIZADOR_CONTADOR_EN`, bench forces the counter to 16'hFFFE, then drives three valid bytes -> `valid_count` reads 16'hFFFF and stays there.
